// File: rtl/tqv_arb_pkg.sv
// Shared definitions for the TinyQV peripheral bus arbiter.
//   - Transaction width codes (also the strobe encodings on data_write_n/data_read_n).
//   - Arbiter FSM state type.
//   - read_mask(): keep-mask for read data of a given transaction width.
package tqv_arb_pkg;

  localparam logic [1:0] TXN_BYTE = 2'b00;
  localparam logic [1:0] TXN_HALF = 2'b01;
  localparam logic [1:0] TXN_WORD = 2'b10;
  localparam logic [1:0] TXN_NONE = 2'b11;  // illegal request / idle strobe

  // Widest data bus the mask helper supports.
  localparam int unsigned MaskW = 64;

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StRd,
    StResp
  } arb_state_e;

  function automatic logic [MaskW-1:0] read_mask(input logic [1:0] txn);
    logic [MaskW-1:0] mask;
    case (txn)
      TXN_BYTE: mask = MaskW'(16'h00ff);
      TXN_HALF: mask = MaskW'(16'hffff);
      default:  mask = '1;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/tqv_rr_pick.sv
// Two-way round-robin picker (purely combinational).
//   req[1:0] : pending requests
//   last     : most recently granted requester
//   valid    : at least one request pending
//   idx      : winning requester; on a tie the one that was not granted last
module tqv_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       idx
);

  always_comb begin
    valid = |req;
    idx   = (&req) ? ~last : req[1];
  end

endmodule

// File: rtl/tqv_bus_arbiter.sv
// Two-requester arbiter/sequencer for the TinyQV peripheral register bus.
// Grants one transaction at a time (round robin), drives registered bus strobes with
// TinyQV timing and returns width-masked read data with a one-cycle ack pulse.
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   req_i/addr_i/wdata_i/we_i/txn_i : per-requester request (held until ack)
//   ack_o/rdata_o/err_o          : per-requester completion, data valid while ack high
//   address/data_in              : bus address / write data (registered)
//   data_write_n/data_read_n     : bus strobes, 2'b11 = idle (registered)
//   data_out/data_ready          : peripheral read data and its valid
//
// Build option: define ARB_TIMEOUT_EN to abort a read with err after TIMEOUT cycles
// without data_ready. Without it, a read waits indefinitely.
module tqv_bus_arbiter
  import tqv_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_i,
  input  logic [1:0][ADDR_W-1:0] addr_i,
  input  logic [1:0][DATA_W-1:0] wdata_i,
  input  logic [1:0]             we_i,
  input  logic [1:0][1:0]        txn_i,
  output logic [1:0]             ack_o,
  output logic [1:0][DATA_W-1:0] rdata_o,
  output logic [1:0]             err_o,
  output logic [ADDR_W-1:0]      address,
  output logic [DATA_W-1:0]      data_in,
  output logic [1:0]             data_write_n,
  output logic [1:0]             data_read_n,
  input  logic [DATA_W-1:0]      data_out,
  input  logic                   data_ready
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       idx_q, idx_d;
  logic [1:0] txn_q, txn_d;

  logic [ADDR_W-1:0]      address_d;
  logic [DATA_W-1:0]      data_in_d;
  logic [1:0]             write_n_d, read_n_d;
  logic [1:0]             ack_d, err_d;
  logic [1:0][DATA_W-1:0] rdata_d;

  logic pick_valid, pick_idx;

  logic [MaskW-1:0]  full_mask;
  logic [DATA_W-1:0] rd_mask;

  tqv_rr_pick u_pick (
    .req   (req_i),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign full_mask = read_mask(txn_q);
  assign rd_mask   = full_mask[DATA_W-1:0];

  if (DATA_W < MaskW) begin : g_mask_hi
    logic unused_mask_hi;
    assign unused_mask_hi = ^full_mask[MaskW-1:DATA_W];
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    idx_d     = idx_q;
    txn_d     = txn_q;
    address_d = address;
    data_in_d = data_in;
    write_n_d = data_write_n;
    read_n_d  = data_read_n;
    ack_d     = '0;
    err_d     = '0;
    rdata_d   = '0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          last_d    = pick_idx;
          idx_d     = pick_idx;
          txn_d     = txn_i[pick_idx];
          address_d = addr_i[pick_idx];
          data_in_d = wdata_i[pick_idx];
          if (txn_i[pick_idx] == TXN_NONE) begin
            // No bus cycle: answer straight away with an error.
            state_d        = StResp;
            ack_d[pick_idx] = 1'b1;
            err_d[pick_idx] = 1'b1;
          end else if (we_i[pick_idx]) begin
            state_d   = StWr;
            write_n_d = txn_i[pick_idx];
          end else begin
            state_d  = StRd;
            read_n_d = txn_i[pick_idx];
`ifdef ARB_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end
        end
      end
      StWr: begin
        state_d      = StResp;
        write_n_d    = TXN_NONE;
        ack_d[idx_q] = 1'b1;
      end
      StRd: begin
        if (data_ready) begin
          state_d        = StResp;
          read_n_d       = TXN_NONE;
          ack_d[idx_q]   = 1'b1;
          rdata_d[idx_q] = data_out & rd_mask;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == TimeoutLast) begin
          state_d      = StResp;
          read_n_d     = TXN_NONE;
          ack_d[idx_q] = 1'b1;
          err_d[idx_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      StResp: begin
        // Ack is visible this cycle; the requester updates req at the closing edge.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_q       <= 1'b1;
      idx_q        <= 1'b0;
      txn_q        <= TXN_NONE;
      address      <= '0;
      data_in      <= '0;
      data_write_n <= TXN_NONE;
      data_read_n  <= TXN_NONE;
      ack_o        <= '0;
      err_o        <= '0;
      rdata_o      <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      idx_q        <= idx_d;
      txn_q        <= txn_d;
      address      <= address_d;
      data_in      <= data_in_d;
      data_write_n <= write_n_d;
      data_read_n  <= read_n_d;
      ack_o        <= ack_d;
      err_o        <= err_d;
      rdata_o      <= rdata_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

endmodule

// File: doc/tqv_bus_arbiter.md
# tqv_bus_arbiter

Two-requester arbiter and sequencer for the TinyQV peripheral register bus (6-bit address, 32-bit data, `data_write_n`/`data_read_n`/`data_ready`). It sits between the peripheral and its bus masters, for example the SPI register bridge and an on-chip test sequencer. It grants one transaction at a time in round-robin order, drives the strobes with TinyQV timing, and returns width-masked read data. An optional timeout guards against a peripheral that never asserts `data_ready`.

## Interface
- `ADDR_W`, default 6: register address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 255: maximum read wait in cycles, used only with `ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset: synchronous, active-high, one clock.
- `req_i[k]`  in  1 (k=0,1)  request; held until ack.
- `addr_i[k]`  in  ADDR_W  register address.
- `wdata_i[k]`  in  DATA_W  write data.
- `we_i[k]`  in  1  1 = write, 0 = read.
- `txn_i[k]`  in  2  width: 00 byte, 01 half, 10 word, 11 illegal.
- `ack_o[k]`  out  1  one-cycle completion pulse.
- `rdata_o[k]`  out  DATA_W  masked read data; valid while ack is high.
- `err_o[k]`  out  1  error flag; valid while ack is high.
- `address`  out  ADDR_W  bus address.
- `data_in`  out  DATA_W  bus write data.
- `data_write_n`  out  2  write strobe; 11 = idle.
- `data_read_n`  out  2  read strobe; 11 = idle.
- `data_out`  in  DATA_W  peripheral read data.
- `data_ready`  in  1  peripheral read-data-valid.

## Operation
- FSM states: IDLE, WR, RD, RESP.
- **IDLE**
  - If any `req_i` is high: pick the winner, then latch its addr/wdata/we/txn and its index.
  - txn=11: go to RESP with err=1 and no bus strobe.
  - Otherwise go to WR if we=1, else RD.
- **Round robin**
  - A `last` pointer records the most recently granted requester.
  - On simultaneous requests, the requester ≠ `last` wins.
  - After reset, `last`=1, so requester 0 wins the first tie.
- **WR**
  - `data_write_n`=txn, `address`/`data_in` driven from the latches, for exactly one cycle.
  - `data_ready` is ignored.
  - Next state: RESP.
- **RD**
  - `data_read_n`=txn held every cycle until `data_ready` is sampled high; `data_ready` in the first RD cycle counts.
  - On `data_ready`: capture `data_out` masked. txn=00 keeps [7:0], 01 keeps [15:0], 10 keeps all bits; the upper bits are zero.
  - Next state: RESP.
- **RESP**
  - `ack_o[idx]`=1 for one cycle with rdata/err. Rdata is 0 for writes and for errors.
  - Next state: IDLE.
- Requester rule: the requester samples ack at the end of RESP and must drop or replace its request at that same edge. IDLE samples the updated `req`.
- A requester that changes `addr_i`/`wdata_i`/`we_i`/`txn_i` while granted has no effect, because the fields are latched.
- Strobes are registered outputs: all of `data_write_n`, `data_read_n`, `address` and `data_in` change only on clk edges.

## Timing
- Reset values:
  - strobes 11;
  - `address`, `data_in`, `rdata_o`, `err_o`, `ack_o` all 0;
  - FSM in IDLE; `last`=1.
- Request first sampled in IDLE at edge n:
  - strobe visible in cycle n+1;
  - write ack in cycle n+2.
  - read ack in cycle n+2+w, where w = number of RD cycles before `data_ready` (w=0 if ready in the first RD cycle).
- Illegal txn: ack with err in cycle n+1.
- Back-to-back throughput: minimum 3 cycles per write (IDLE, WR, RESP).
- Both requesters continuously active: grants alternate 0,1,0,1.
- Reset mid-transaction: at the next edge, strobes go to 11, the FSM goes to IDLE, and no ack is issued for the aborted transaction.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit cycle counter runs in RD.
  - If it reaches `TIMEOUT` without `data_ready`, the FSM drops the strobe and enters RESP with err=1 and rdata=0.
  - The counter clears on entry to RD.
- `ARB_TIMEOUT_EN` undefined:
  - No counter; RD waits indefinitely.
  - `err_o` is set only for txn=11.

## Structure
- Package `tqv_arb_pkg`: txn width constants (`TXN_BYTE`, `TXN_HALF`, `TXN_WORD`, `TXN_NONE`), the FSM state enum, and the read-mask function.
- Sub-module `tqv_rr_pick`: 2-way round-robin picker. Inputs: `req[1:0]`, `last`. Outputs: `valid`, `idx`. Purely combinational.
- Top-level module holds the FSM, the latches, the timeout counter and the response registers.

## Test plan
- Reset, then requester 0 writes addr 0x05, data 0xDEADBEEF, txn=10 → exactly one cycle of `data_write_n`=10 with address 0x05 and `data_in` 0xDEADBEEF; `ack_o[0]` 2 cycles after the request is sampled; err=0.
- Requester 1 reads addr 0x3F, txn=00; peripheral returns `data_out` 0x12345678 with `data_ready` 3 cycles late → `data_read_n`=00 held 4 cycles; `rdata_o[1]`=0x00000078, ack at n+5.
- Both requesters assert reads at the same edge after reset, held through 4 transactions → grant order 0,1,0,1; never two strobes at once.
- Requester 0 uses txn=11 → ack with err=1 one cycle after sampling; `data_write_n`/`data_read_n` stay 11 throughout.
- With `ARB_TIMEOUT_EN`, TIMEOUT=4, `data_ready` held low → strobe held 4 cycles, then ack with err=1 and rdata 0. Without the macro, the strobe is still held after 300 cycles.
- `rst` pulsed during RD → strobes 11 on the next edge, no ack; a following write completes normally.
